// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: shares the single register-file write port between
// requester A (ALU writeback) and requester B (load / multi-cycle unit).
// Grants at most one write per cycle, registers it into the output stage,
// suppresses writes to $0, and supplies bypass data for two read ports.
// Optional feature: define RF_ARB_RR_EN for round-robin arbitration;
// otherwise A has fixed priority over B.
module rf_write_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        a_valid,
    input  logic [4:0]  a_reg,
    input  logic [31:0] a_data,
    output logic        a_ready,
    input  logic        b_valid,
    input  logic [4:0]  b_reg,
    input  logic [31:0] b_data,
    output logic        b_ready,
    input  logic        hold,
    output logic        RegWrite,
    output logic [4:0]  writereg,
    output logic [31:0] writedata,
    input  logic [4:0]  readreg1,
    input  logic [4:0]  readreg2,
    output logic        fwd1_hit,
    output logic        fwd2_hit,
    output logic [31:0] fwd1_data,
    output logic [31:0] fwd2_data,
    output logic [15:0] contention
);

    localparam int unsigned REG_W  = 5;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = 16;

    logic a_wins_tie;

`ifdef RF_ARB_RR_EN
    logic last_b;

    // Last-granted pointer: 1 means B was granted last, so A wins the next tie
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_b <= 1'b1;
        end else if (a_ready) begin
            last_b <= 1'b0;
        end else if (b_ready) begin
            last_b <= 1'b1;
        end
    end

    assign a_wins_tie = last_b;
`else
    assign a_wins_tie = 1'b1;
`endif

    // Grant selection: depends only on valids, hold and arbitration state
    always_comb begin
        a_ready = 1'b0;
        b_ready = 1'b0;
        if (!hold) begin
            if (a_valid && (!b_valid || a_wins_tie)) begin
                a_ready = 1'b1;
            end else if (b_valid) begin
                b_ready = 1'b1;
            end
        end
    end

    // Output stage: capture the granted write; $0 completes but never writes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            RegWrite  <= 1'b0;
            writereg  <= REG_W'(0);
            writedata <= DATA_W'(0);
        end else if (a_ready) begin
            RegWrite  <= (a_reg != REG_W'(0));
            writereg  <= a_reg;
            writedata <= a_data;
        end else if (b_ready) begin
            RegWrite  <= (b_reg != REG_W'(0));
            writereg  <= b_reg;
            writedata <= b_data;
        end else begin
            RegWrite  <= 1'b0;
        end
    end

    // Saturating count of cycles where both requesters competed unheld
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            contention <= CNT_W'(0);
        end else if (a_valid && b_valid && !hold && (contention != {CNT_W{1'b1}})) begin
            contention <= contention + CNT_W'(1);
        end
    end

    // Bypass for the write currently presented to the register file
    assign fwd1_hit  = RegWrite && (writereg == readreg1);
    assign fwd2_hit  = RegWrite && (writereg == readreg2);
    assign fwd1_data = writedata;
    assign fwd2_data = writedata;

endmodule

// File: doc/rf_write_arbiter.md
# rf_write_arbiter

Shares the register file's single write port (writereg/writedata/RegWrite) between two writeback requesters: requester A (ALU writeback) and requester B (load / multi-cycle unit). It grants at most one write per cycle, registers the winning write into an output stage that drives the register file, and suppresses writes to $0. It also supplies bypass data for the two read ports during the cycle a write is in flight. It sits between the execute/memory writeback sources and the register file.

## Interface
- No parameters. Widths are fixed: 5-bit register index, 32-bit data.
- clk  in  1  rising-edge clock shared with the register file
- rst  in  1  asynchronous, active-high reset
- a_valid  in  1  requester A has a write pending
- a_reg  in  5  requester A destination register
- a_data  in  32  requester A write data
- a_ready  out  1  requester A granted this cycle (combinational)
- b_valid  in  1  requester B has a write pending
- b_reg  in  5  requester B destination register
- b_data  in  32  requester B write data
- b_ready  out  1  requester B granted this cycle (combinational)
- hold  in  1  blocks all grants while high
- RegWrite  out  1  register-file write enable (registered)
- writereg  out  5  register-file write index (registered)
- writedata  out  32  register-file write data (registered)
- readreg1, readreg2  in  5  read indices currently presented to the register file
- fwd1_hit, fwd2_hit  out  1  in-flight write targets readreg1 / readreg2
- fwd1_data, fwd2_data  out  32  bypass data; equals writedata
- contention  out  16  saturating count of cycles in which both requesters were valid and not held

## Operation
- **Grant:**
  - A transfer completes in any cycle where x_valid && x_ready.
  - At most one of a_ready / b_ready is high in a cycle.
  - Both are 0 when hold=1.
  - x_ready never depends on x_ready of the other port. It is a function of a_valid, b_valid, hold and the arbitration state only.
- **Arbitration (default):** fixed priority, A over B. If only one requester is valid, that requester is granted.
- **Output stage:** loads on every clock edge.
  - On a grant: RegWrite = (granted reg != 0), writereg = granted reg, writedata = granted data.
  - With no grant: RegWrite = 0, and writereg/writedata hold their previous values.
- **$0 writes:** the handshake completes normally (ready=1), but RegWrite stays 0.
- **Bypass:**
  - fwdN_hit = RegWrite && (writereg == readregN).
  - fwdN_data = writedata, unconditionally.
  - Because RegWrite is 0 for $0 writes, a read of $0 never hits.
- **Contention counter:**
  - Increments when a_valid && b_valid && !hold.
  - Saturates at 16'hFFFF.
- **Reset (asynchronous):** RegWrite=0, writereg=0, writedata=0, contention=0, and the arbitration state is cleared. Any write captured in the output stage is discarded. Reset mid-operation loses in-flight writes, and this is the required behaviour.

## Timing
- A grant in cycle N puts RegWrite/writereg/writedata on the outputs during cycle N+1. The register file commits at the end of N+1, so the source-to-commit latency is 2 edges.
- Sustained throughput: one write per cycle. There is no backpressure from the register file.
- A grant in every consecutive cycle produces RegWrite high for consecutive cycles with no bubble.
- The bypass is valid only in cycle N+1. From N+2 the register file itself returns the new value.
- hold asserting in cycle N blocks the grant in N. Any write granted in N-1 still appears in N and is not cancelled.
- When A and B target the same register in the same cycle, only one is granted. The loser's write follows in a later cycle and its value is the final one.
- a_ready and b_ready have a combinational path from a_valid, b_valid and hold. There are no registered-ready semantics.

## Configuration
- **RF_ARB_RR_EN defined:** round-robin arbitration.
  - A 1-bit last-granted pointer updates only on a grant.
  - When both requesters are valid, the one not last granted wins.
  - Reset sets the pointer to "B last granted", so A wins the first tie.
  - hold cycles and single-requester grants update the pointer normally.
- **RF_ARB_RR_EN undefined:** fixed priority A>B, with no pointer flop. B can starve while A is continuously valid.

## Test plan
- **Reset:** assert rst mid-stream while RegWrite=1 -> outputs go to RegWrite=0, writereg=0, writedata=0, contention=0 immediately, without waiting for a clock edge.
- **Single A write:** a_valid=1, a_reg=5, a_data=32'h0000_000A for one cycle -> a_ready=1 that cycle; next cycle RegWrite=1, writereg=5, writedata=32'hA. With readreg1=5 in that cycle -> fwd1_hit=1, fwd1_data=32'hA.
- **$0 filter:** B writes reg 0, data 32'hDEAD_BEEF -> b_ready=1; next cycle RegWrite=0; readreg1=0 -> fwd1_hit=0.
- **Tie, fixed priority (RF_ARB_RR_EN undefined):** both valid for 3 cycles (A reg 1/2/3, B reg 7) -> A is granted 3 times and B 0 times; contention=3; B is granted in the 4th cycle after A drops.
- **Tie, round-robin (RF_ARB_RR_EN defined):** both continuously valid for 4 cycles -> grants A, B, A, B; writereg sequence matches, one cycle delayed.
- **hold:** hold=1 for 2 cycles with both valid -> no ready, RegWrite=0 one cycle later, contention unchanged. Release -> grant resumes in the same cycle.
